// File: rtl/csr_write_queue.sv
// csr_write_queue: collects write-only CSR updates from NCH writer channels,
// arbitrates them round-robin into a small FIFO and drains it to one target.
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   wr_strobe       per-channel write request pulse
//   wr_data         per-channel write data, slice i = [i*WIDTH +: WIDTH]
//   wr_wait         per-channel busy (combinational)
//   wr_done_strobe  per-channel pulse when the target has taken the write
//   out_valid       FIFO head valid
//   out_ready       target accepts the head this cycle
//   out_ch          channel index of the head entry
//   out_data        data of the head entry
//   last_data       per-channel shadow of the last value taken by the target
//   fifo_count      number of FIFO entries
module csr_write_queue #(
    parameter int               WIDTH       = 32,
    parameter int               NCH         = 4,
    parameter int               DEPTH       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               CHW         = (NCH > 1) ? $clog2(NCH) : 1,
    parameter int               CW          = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       wr_strobe,
    input  logic [NCH*WIDTH-1:0] wr_data,
    output logic [NCH-1:0]       wr_wait,
    output logic [NCH-1:0]       wr_done_strobe,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CHW-1:0]       out_ch,
    output logic [WIDTH-1:0]     out_data,
    output logic [NCH*WIDTH-1:0] last_data,
    output logic [CW-1:0]        fifo_count
);

    localparam int              PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0]   PTR_MAX = PW'(DEPTH - 1);
    localparam logic [CHW-1:0]  CH_MAX  = CHW'(NCH - 1);

    logic [NCH-1:0]   pending;
    logic [NCH-1:0]   inflight;
    logic [NCH-1:0]   wait_1a;
    logic [WIDTH-1:0] hold [NCH];
    logic [WIDTH-1:0] last_q [NCH];
    logic [CHW-1:0]   rr;

    logic [CHW-1:0]   fifo_ch [DEPTH];
    logic [WIDTH-1:0] fifo_data [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;

    logic [NCH-1:0]   eligible;
    logic             grant;
    logic [CHW-1:0]   gnt;
    logic             pop;
    logic [NCH-1:0]   pending_n;
    logic [NCH-1:0]   inflight_n;

    assign wr_wait        = wr_strobe | pending | inflight;
    assign wr_done_strobe = ~wr_wait & wait_1a;

    assign out_valid  = (count != '0);
    assign out_ch     = fifo_ch[rd_ptr];
    assign out_data   = fifo_data[rd_ptr];
    assign fifo_count = count;
    assign pop        = out_valid & out_ready;

    assign eligible = pending & ~inflight;

    for (genvar i = 0; i < NCH; i++) begin : g_last
        assign last_data[i*WIDTH +: WIDTH] = last_q[i];
    end

    // Round-robin search upward from rr. A pop in the same cycle does not
    // open a slot: the grant only looks at the current count.
    always_comb begin
        int j;
        logic [CHW-1:0] idx;
        grant = 1'b0;
        gnt   = '0;
        j     = 0;
        idx   = '0;
        if (count < DEPTH_C) begin
            for (int k = 0; k < NCH; k++) begin
                j = int'(rr) + k;
                if (j >= NCH) j = j - NCH;
                idx = CHW'(j);
                if (!grant && eligible[idx]) begin
                    grant = 1'b1;
                    gnt   = idx;
                end
            end
        end
    end

    // A strobe on the granted channel keeps it pending; the pushed entry
    // carries the previous hold value.
    always_comb begin
        pending_n  = pending;
        inflight_n = inflight;
        if (grant) begin
            pending_n[gnt]  = 1'b0;
            inflight_n[gnt] = 1'b1;
        end
        if (pop) begin
            inflight_n[out_ch] = 1'b0;
        end
        pending_n = pending_n | wr_strobe;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= '0;
            inflight <= '0;
            wait_1a  <= '0;
            rr       <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            for (int i = 0; i < NCH; i++) begin
                hold[i]   <= '0;
                last_q[i] <= RESET_VALUE;
            end
            for (int i = 0; i < DEPTH; i++) begin
                fifo_ch[i]   <= '0;
                fifo_data[i] <= '0;
            end
        end else begin
            pending  <= pending_n;
            inflight <= inflight_n;
            wait_1a  <= wr_wait;
            for (int i = 0; i < NCH; i++) begin
                if (wr_strobe[i]) begin
                    hold[i] <= wr_data[i*WIDTH +: WIDTH];
                end
            end
            if (grant) begin
                fifo_ch[wr_ptr]   <= gnt;
                fifo_data[wr_ptr] <= hold[gnt];
                wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
                rr     <= (gnt == CH_MAX) ? '0 : gnt + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;
                last_q[out_ch] <= out_data;
            end
            case ({grant, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_write_queue.sv
// tb_csr_write_queue: directed and random stimulus against a queue-based
// reference model; a negedge monitor scores every output each cycle.
module tb_csr_write_queue;

    localparam int WIDTH = 32;
    localparam int NCH   = 4;
    localparam int DEPTH = 2;
    localparam int LW    = NCH * WIDTH;
    localparam int CHW   = 2;
    localparam int CW    = 2;
    localparam logic [WIDTH-1:0] RV = 32'h0;

    logic           clk;
    logic           rst;
    logic [NCH-1:0] wr_strobe;
    logic [LW-1:0]  wr_data;
    logic [NCH-1:0] wr_wait;
    logic [NCH-1:0] wr_done_strobe;
    logic           out_valid;
    logic           out_ready;
    logic [CHW-1:0] out_ch;
    logic [WIDTH-1:0] out_data;
    logic [LW-1:0]  last_data;
    logic [CW-1:0]  fifo_count;

    csr_write_queue #(
        .WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH), .RESET_VALUE(RV)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_strobe(wr_strobe), .wr_data(wr_data),
        .wr_wait(wr_wait), .wr_done_strobe(wr_done_strobe),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ch(out_ch), .out_data(out_data),
        .last_data(last_data), .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [LW-1:0] act,
                       input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp,
                     $time);
        end
    endtask

    // Reference model: pending/inflight flags per channel, FIFO as a queue.
    typedef struct {
        int               ch;
        logic [WIDTH-1:0] d;
    } ent_t;

    ent_t             sb[$];
    logic [NCH-1:0]   m_pend = '0;
    logic [NCH-1:0]   m_infl = '0;
    logic [NCH-1:0]   m_w1a  = '0;
    logic [WIDTH-1:0] m_hold [NCH];
    logic [WIDTH-1:0] m_last [NCH];
    int               m_rr   = 0;

    function automatic void model_reset();
        m_pend = '0;
        m_infl = '0;
        m_w1a  = '0;
        m_rr   = 0;
        sb.delete();
        for (int i = 0; i < NCH; i++) begin
            m_hold[i] = '0;
            m_last[i] = RV;
        end
    endfunction

    task automatic model_step(input logic [NCH-1:0] ew);
        int   g;
        int   n0;
        ent_t e;
        g  = -1;
        n0 = sb.size();
        if (n0 < DEPTH) begin
            for (int k = 0; k < NCH; k++) begin
                int j;
                j = (m_rr + k) % NCH;
                if (g < 0 && m_pend[j] && !m_infl[j]) g = j;
            end
        end
        if (out_ready && n0 != 0) begin
            e = sb.pop_front();
            chk("pop_ch", LW'(out_ch), LW'(e.ch));
            chk("pop_data", LW'(out_data), LW'(e.d));
            m_infl[e.ch] = 1'b0;
            m_last[e.ch] = e.d;
        end else if (out_ready && out_valid) begin
            chk("pop_underflow", 1, 0);
        end
        if (g >= 0) begin
            e.ch = g;
            e.d  = m_hold[g];
            sb.push_back(e);
            m_infl[g] = 1'b1;
            m_pend[g] = 1'b0;
            m_rr = (g + 1) % NCH;
        end
        for (int i = 0; i < NCH; i++) begin
            if (wr_strobe[i]) begin
                m_pend[i] = 1'b1;
                m_hold[i] = wr_data[i*WIDTH +: WIDTH];
            end
        end
        m_w1a = ew;
    endtask

    initial model_reset();

    always @(negedge clk) begin
        logic [NCH-1:0] ew;
        logic [LW-1:0]  el;
        if (rst) begin
            model_reset();
            chk("rst_valid", LW'(out_valid), 0);
            chk("rst_count", LW'(fifo_count), 0);
            chk("rst_done", LW'(wr_done_strobe), 0);
            chk("rst_last", last_data, {NCH{RV}});
        end else begin
            ew = wr_strobe | m_pend | m_infl;
            chk("wait", LW'(wr_wait), LW'(ew));
            chk("done", LW'(wr_done_strobe), LW'(~ew & m_w1a));
            chk("count", LW'(fifo_count), LW'(sb.size()));
            chk("valid", LW'(out_valid), LW'(sb.size() != 0));
            if (fifo_count > CW'(DEPTH)) chk("count_max", LW'(fifo_count), DEPTH);
            if (sb.size() != 0) begin
                chk("head_ch", LW'(out_ch), LW'(sb[0].ch));
                chk("head_data", LW'(out_data), LW'(sb[0].d));
            end
            for (int i = 0; i < NCH; i++) el[i*WIDTH +: WIDTH] = m_last[i];
            chk("last", last_data, el);
            model_step(ew);
        end
    end

    function automatic logic [LW-1:0] one(input int ch, input logic [WIDTH-1:0] v);
        logic [LW-1:0] d;
        d = '0;
        d[ch*WIDTH +: WIDTH] = v;
        return d;
    endfunction

    function automatic logic [LW-1:0] rnd();
        logic [LW-1:0] d;
        for (int i = 0; i < NCH; i++) d[i*WIDTH +: WIDTH] = $urandom;
        return d;
    endfunction

    task automatic cyc(input logic [NCH-1:0] s, input logic [LW-1:0] d,
                       input logic r);
        wr_strobe = s;
        wr_data   = d;
        out_ready = r;
        @(posedge clk);
        #1;
        wr_strobe = '0;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) cyc('0, '0, r);
    endtask

    task automatic do_reset();
        wr_strobe = '0;
        rst = 1'b1;
        #1;
        chk("arst_valid", LW'(out_valid), 0);
        chk("arst_count", LW'(fifo_count), 0);
        chk("arst_wait", LW'(wr_wait), 0);
        chk("arst_done", LW'(wr_done_strobe), 0);
        chk("arst_last", last_data, {NCH{RV}});
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        wr_strobe = '0;
        wr_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // single write: latency and done timing
        cyc(4'b0001, one(0, 32'hDEADBEEF), 1'b1);
        chk("t1_n1_valid", LW'(out_valid), 0);
        cyc('0, '0, 1'b1);
        chk("t1_n2_valid", LW'(out_valid), 1);
        chk("t1_n2_data", LW'(out_data), 32'hDEADBEEF);
        chk("t1_n2_ch", LW'(out_ch), 0);
        cyc('0, '0, 1'b1);
        chk("t1_n3_done", LW'(wr_done_strobe), 4'b0001);
        chk("t1_n3_wait", LW'(wr_wait), 0);
        chk("t1_last", LW'(last_data[WIDTH-1:0]), 32'hDEADBEEF);
        idle(3, 1'b1);

        // round robin, all channels at once
        cyc(4'b1111, rnd(), 1'b1);
        idle(10, 1'b1);

        // coalesce into a granted slot
        cyc(4'b0010, one(1, 32'h11), 1'b0);
        cyc(4'b0010, one(1, 32'h22), 1'b0);
        idle(3, 1'b0);
        idle(6, 1'b1);

        // coalesce while FIFO is full
        cyc(4'b1001, rnd(), 1'b0);
        idle(3, 1'b0);
        cyc(4'b0100, one(2, 32'h33), 1'b0);
        cyc(4'b0010, one(1, 32'h11), 1'b0);
        cyc(4'b0010, one(1, 32'h22), 1'b0);
        idle(3, 1'b0);
        idle(10, 1'b1);

        // backpressure
        cyc(4'b1111, rnd(), 1'b0);
        idle(20, 1'b0);
        chk("bp_count", LW'(fifo_count), DEPTH);
        chk("bp_wait", LW'(wr_wait), 4'b1111);
        idle(12, 1'b1);

        // strobe during grant
        cyc(4'b1000, one(3, 32'h5), 1'b1);
        cyc(4'b1000, one(3, 32'hA), 1'b1);
        idle(8, 1'b1);

        // reset mid-operation
        cyc(4'b1111, rnd(), 1'b0);
        idle(3, 1'b0);
        do_reset();
        idle(5, 1'b1);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [NCH-1:0] s;
            logic r;
            for (int i = 0; i < NCH; i++) s[i] = ($urandom_range(0, 3) == 0);
            r = (n % 200 < 150) ? ($urandom_range(0, 3) != 0)
                                : ($urandom_range(0, 7) == 0);
            cyc(s, rnd(), r);
            if (n == 1500) do_reset();
        end
        idle(20, 1'b1);
        chk("drained", LW'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
